// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through a background-music ROM and overlays short,
// prioritized sound effects, feeding the speaker square-wave generator.
// The generator toggles its output every half_period_o+1 clocks while tone_en_o=1.
// Ports:
//   clk              system clock (25 MHz nominal)
//   rst_n            asynchronous active-low reset
//   play_i           level, 1 = background music enabled
//   sfx_trig_i[1:0]  one-cycle event: 00 none, 01 drop, 10 line clear, 11 game over
//   half_period_o    registered divider value, 0 while silent
//   tone_en_o        registered tone enable
//   note_idx_o[4:0]  registered current music ROM index
//   sfx_busy_o       registered, 1 while a sound effect plays
// Build option: define MELODY_RESUME_EN to keep the ROM index when music is
// paused, so the next play resumes from that entry instead of entry 0.
module melody_sequencer #(
    parameter int unsigned TICK_DIV = 250000,
    parameter int unsigned SONG_LEN = 32,
    parameter int unsigned HP_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            play_i,
    input  logic [1:0]      sfx_trig_i,
    output logic [HP_W-1:0] half_period_o,
    output logic            tone_en_o,
    output logic [4:0]      note_idx_o,
    output logic            sfx_busy_o
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [4:0]       IDX_LAST = 5'(SONG_LEN - 1);

    // Half-period values for 25 MHz (12.5e6 / f)
    localparam logic [15:0] N_R  = 16'd0;
    localparam logic [15:0] N_A4 = 16'd28409;
    localparam logic [15:0] N_B4 = 16'd25304;
    localparam logic [15:0] N_C5 = 16'd23889;
    localparam logic [15:0] N_D5 = 16'd21283;
    localparam logic [15:0] N_E5 = 16'd18968;
    localparam logic [15:0] N_F5 = 16'd17897;
    localparam logic [15:0] N_G5 = 16'd15944;
    localparam logic [15:0] N_A5 = 16'd14205;

    typedef enum logic [1:0] {ST_IDLE, ST_MUSIC, ST_GAP, ST_SFX} state_e;

    state_e          state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [4:0]      note_idx_q, note_idx_d;
    logic [5:0]      dur_cnt_q, dur_cnt_d;
    logic [1:0]      sfx_code_q, sfx_code_d;
    logic [1:0]      sfx_step_q, sfx_step_d;
    logic [2:0]      sfx_tick_q, sfx_tick_d;
    logic [HP_W-1:0] hp_q, hp_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic [4:0]      idx_out_q;

    // Music ROM: {half period, duration in ticks}; the last entry is always a rest
    function automatic logic [21:0] rom_entry(input logic [4:0] idx);
        logic [21:0] e;
        case (idx)
            5'd0:  e = {N_E5, 6'd20};
            5'd1:  e = {N_B4, 6'd10};
            5'd2:  e = {N_C5, 6'd10};
            5'd3:  e = {N_D5, 6'd20};
            5'd4:  e = {N_C5, 6'd10};
            5'd5:  e = {N_B4, 6'd10};
            5'd6:  e = {N_A4, 6'd20};
            5'd7:  e = {N_A4, 6'd10};
            5'd8:  e = {N_C5, 6'd10};
            5'd9:  e = {N_E5, 6'd20};
            5'd10: e = {N_D5, 6'd10};
            5'd11: e = {N_C5, 6'd10};
            5'd12: e = {N_B4, 6'd30};
            5'd13: e = {N_C5, 6'd10};
            5'd14: e = {N_D5, 6'd20};
            5'd15: e = {N_E5, 6'd20};
            5'd16: e = {N_C5, 6'd20};
            5'd17: e = {N_A4, 6'd20};
            5'd18: e = {N_A4, 6'd20};
            5'd19: e = {N_R,  6'd10};
            5'd20: e = {N_D5, 6'd30};
            5'd21: e = {N_F5, 6'd10};
            5'd22: e = {N_A5, 6'd20};
            5'd23: e = {N_G5, 6'd10};
            5'd24: e = {N_F5, 6'd10};
            5'd25: e = {N_E5, 6'd30};
            5'd26: e = {N_C5, 6'd10};
            5'd27: e = {N_E5, 6'd20};
            5'd28: e = {N_D5, 6'd10};
            5'd29: e = {N_C5, 6'd10};
            5'd30: e = {N_B4, 6'd20};
            default: e = {N_R, 6'd20};
        endcase
        if (idx == IDX_LAST) e = {N_R, 6'd20};
        return e;
    endfunction

    // Sound-effect tone table indexed by {code, step}
    function automatic logic [15:0] sfx_hp(input logic [1:0] code, input logic [1:0] step);
        logic [15:0] hp;
        case ({code, step})
            4'b01_00: hp = 16'd28409;
            4'b10_00: hp = 16'd28409;
            4'b10_01: hp = 16'd22563;
            4'b10_10: hp = 16'd18968;
            4'b11_00: hp = 16'd18968;
            4'b11_01: hp = 16'd22563;
            4'b11_10: hp = 16'd28409;
            4'b11_11: hp = 16'd37879;
            default:  hp = 16'd0;
        endcase
        return hp;
    endfunction

    function automatic logic [2:0] sfx_last_tick(input logic [1:0] code);
        case (code)
            2'd1:    return 3'd2;
            2'd2:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [1:0] sfx_last_step(input logic [1:0] code);
        case (code)
            2'd1:    return 2'd0;
            2'd2:    return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    logic        tick_c;
    logic        sfx_start_c;
    logic [21:0] entry_c;
    logic [15:0] rom_hp_c;
    logic [5:0]  dur_last_c;
    logic [4:0]  idx_next_c;
    logic [4:0]  idx_leave_c;

    assign tick_c     = (presc_q == PRE_LAST);
    assign entry_c    = rom_entry(note_idx_q);
    assign rom_hp_c   = entry_c[21:6];
    // A zero duration plays as a single tick
    assign dur_last_c = (entry_c[5:0] == 6'd0) ? 6'd0 : entry_c[5:0] - 6'd1;
    assign idx_next_c = (note_idx_q == IDX_LAST) ? 5'd0 : note_idx_q + 5'd1;
    // Only a strictly higher code may preempt a running effect
    assign sfx_start_c = (state_q == ST_SFX) ? (sfx_trig_i > sfx_code_q)
                                              : (sfx_trig_i != 2'b00);
`ifdef MELODY_RESUME_EN
    assign idx_leave_c = note_idx_q;
`else
    assign idx_leave_c = 5'd0;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            note_idx_q <= '0;
            dur_cnt_q  <= '0;
            sfx_code_q <= '0;
            sfx_step_q <= '0;
            sfx_tick_q <= '0;
            hp_q       <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            idx_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            note_idx_q <= note_idx_d;
            dur_cnt_q  <= dur_cnt_d;
            sfx_code_q <= sfx_code_d;
            sfx_step_q <= sfx_step_d;
            sfx_tick_q <= sfx_tick_d;
            hp_q       <= hp_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            idx_out_q  <= note_idx_q;
        end
    end

    // Next-state and counter logic; a trigger takes precedence over a tick
    always_comb begin
        state_d    = state_q;
        presc_d    = tick_c ? '0 : presc_q + PRE_W'(1);
        note_idx_d = note_idx_q;
        dur_cnt_d  = dur_cnt_q;
        sfx_code_d = sfx_code_q;
        sfx_step_d = sfx_step_q;
        sfx_tick_d = sfx_tick_q;
        if (sfx_start_c) begin
            state_d    = ST_SFX;
            sfx_code_d = sfx_trig_i;
            sfx_step_d = '0;
            sfx_tick_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (play_i) begin
                        state_d   = ST_MUSIC;
                        dur_cnt_d = '0;
                    end
                end
                ST_MUSIC: begin
                    if (!play_i) begin
                        state_d    = ST_IDLE;
                        note_idx_d = idx_leave_c;
                    end else if (tick_c) begin
                        if (dur_cnt_q == dur_last_c) begin
                            state_d   = ST_GAP;
                            dur_cnt_d = '0;
                        end else begin
                            dur_cnt_d = dur_cnt_q + 6'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (!play_i) begin
                        state_d    = ST_IDLE;
                        note_idx_d = idx_leave_c;
                    end else if (tick_c) begin
                        state_d    = ST_MUSIC;
                        note_idx_d = idx_next_c;
                        dur_cnt_d  = '0;
                    end
                end
                ST_SFX: begin
                    if (tick_c) begin
                        if (sfx_tick_q == sfx_last_tick(sfx_code_q)) begin
                            sfx_tick_d = '0;
                            if (sfx_step_q == sfx_last_step(sfx_code_q)) begin
                                if (play_i) begin
                                    state_d   = ST_MUSIC;
                                    dur_cnt_d = '0;
                                end else begin
                                    state_d    = ST_IDLE;
                                    note_idx_d = idx_leave_c;
                                end
                            end else begin
                                sfx_step_d = sfx_step_q + 2'd1;
                            end
                        end else begin
                            sfx_tick_d = sfx_tick_q + 3'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode from the current state, registered one cycle later
    always_comb begin
        hp_d   = '0;
        en_d   = 1'b0;
        busy_d = 1'b0;
        case (state_q)
            ST_MUSIC: begin
                hp_d = HP_W'(rom_hp_c);
                en_d = (rom_hp_c != 16'd0);
            end
            ST_SFX: begin
                hp_d   = HP_W'(sfx_hp(sfx_code_q, sfx_step_q));
                en_d   = 1'b1;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign half_period_o = hp_q;
    assign tone_en_o     = en_q;
    assign note_idx_o    = idx_out_q;
    assign sfx_busy_o    = busy_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed and randomized stimulus for melody_sequencer,
// checked every cycle against a tick-countdown reference model of the sequencer.
module tb_melody_sequencer;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned SONG_LEN = 32;
    localparam int unsigned HP_W     = 16;
    localparam int M_IDLE = 0, M_MUSIC = 1, M_GAP = 2, M_SFX = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            play_i;
    logic [1:0]      sfx_trig_i;
    logic [HP_W-1:0] half_period_o;
    logic            tone_en_o;
    logic [4:0]      note_idx_o;
    logic            sfx_busy_o;

    int errors = 0;
    int checks = 0;

    melody_sequencer #(
        .TICK_DIV(TICK_DIV),
        .SONG_LEN(SONG_LEN),
        .HP_W    (HP_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .play_i       (play_i),
        .sfx_trig_i   (sfx_trig_i),
        .half_period_o(half_period_o),
        .tone_en_o    (tone_en_o),
        .note_idx_o   (note_idx_o),
        .sfx_busy_o   (sfx_busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Song as the player hears it
    int song_hp [SONG_LEN] = '{18968, 25304, 23889, 21283, 23889, 25304, 28409, 28409,
                               23889, 18968, 21283, 23889, 25304, 23889, 21283, 18968,
                               23889, 28409, 28409, 0,     21283, 17897, 14205, 15944,
                               17897, 18968, 23889, 18968, 21283, 23889, 25304, 0};
    int song_dt [SONG_LEN] = '{20, 10, 10, 20, 10, 10, 20, 10, 10, 20, 10, 10, 30, 10, 20, 20,
                               20, 20, 20, 10, 30, 10, 20, 10, 10, 30, 10, 20, 10, 10, 20, 20};

    // Reference model: mode, remaining ticks, and a queue of pending effect tones
    int m_mode, m_idx, m_rem, m_code, m_trem, m_n;
    int sfx_q[$];
    int exp_hp, exp_en, exp_busy, exp_idx;

    function automatic int song_dur(input int idx);
        return (song_dt[idx] == 0) ? 1 : song_dt[idx];
    endfunction

    function automatic int sfx_ticks(input int code);
        case (code)
            1:       return 3;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_idx = 0; m_rem = 0; m_code = 0; m_trem = 0; m_n = 0;
        sfx_q.delete();
    endtask

    task automatic start_sfx(input int code);
        m_mode = M_SFX;
        m_code = code;
        m_trem = sfx_ticks(code);
        case (code)
            1:       sfx_q = '{28409};
            2:       sfx_q = '{28409, 22563, 18968};
            default: sfx_q = '{18968, 22563, 28409, 37879};
        endcase
    endtask

    task automatic go_idle();
        m_mode = M_IDLE;
`ifndef MELODY_RESUME_EN
        m_idx = 0;
`endif
    endtask

    // Advance the model across one clock edge; expected outputs reflect the pre-edge state
    task automatic model_edge(input logic play, input logic [1:0] trig);
        bit tk;
        tk = ((m_n % TICK_DIV) == TICK_DIV - 1);
        m_n++;
        exp_idx  = m_idx;
        exp_busy = (m_mode == M_SFX) ? 1 : 0;
        exp_hp   = (m_mode == M_MUSIC) ? song_hp[m_idx] : (m_mode == M_SFX) ? sfx_q[0] : 0;
        exp_en   = (m_mode == M_SFX) ? 1 : ((m_mode == M_MUSIC && song_hp[m_idx] != 0) ? 1 : 0);
        if (m_mode == M_SFX) begin
            if (int'(trig) > m_code) start_sfx(int'(trig));
            else if (tk) begin
                m_trem--;
                if (m_trem == 0) begin
                    void'(sfx_q.pop_front());
                    if (sfx_q.size() == 0) begin
                        if (play) begin m_mode = M_MUSIC; m_rem = song_dur(m_idx); end
                        else go_idle();
                    end else begin
                        m_trem = sfx_ticks(m_code);
                    end
                end
            end
        end else if (trig != 2'b00) begin
            start_sfx(int'(trig));
        end else if (m_mode == M_IDLE) begin
            if (play) begin m_mode = M_MUSIC; m_rem = song_dur(m_idx); end
        end else if (!play) begin
            go_idle();
        end else if (tk) begin
            if (m_mode == M_MUSIC) begin
                m_rem--;
                if (m_rem == 0) m_mode = M_GAP;
            end else begin
                m_idx  = (m_idx + 1) % SONG_LEN;
                m_mode = M_MUSIC;
                m_rem  = song_dur(m_idx);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, step the model, sample #1 after the edge and compare
    task automatic cyc(input logic play, input logic [1:0] trig);
        play_i     = play;
        sfx_trig_i = trig;
        model_edge(play, trig);
        @(posedge clk);
        #1;
        sfx_trig_i = 2'b00;
        chk("half_period", 32'(half_period_o), exp_hp);
        chk("tone_en", 32'(tone_en_o), exp_en);
        chk("note_idx", 32'(note_idx_o), exp_idx);
        chk("sfx_busy", 32'(sfx_busy_o), exp_busy);
    endtask

    initial begin
        int found, gap_cycles, saw31, rest_bad, wrapped;
        int seen[$];
        int lc_exp[3] = '{28409, 22563, 18968};
        logic p;
        logic [1:0] t;

        rst_n = 1'b0; play_i = 1'b0; sfx_trig_i = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_half_period", 32'(half_period_o), 0);
        chk("rst_tone_en", 32'(tone_en_o), 0);
        chk("rst_note_idx", 32'(note_idx_o), 0);
        chk("rst_sfx_busy", 32'(sfx_busy_o), 0);
        rst_n = 1'b1;

        // First note appears one cycle after PLAY is sampled
        cyc(1'b1, 2'b00);
        cyc(1'b1, 2'b00);
        chk("first_hp", 32'(half_period_o), 18968);
        chk("first_en", 32'(tone_en_o), 1);

        // Entry 0 plays, one-tick silent gap, then entry 1
        found = 0; gap_cycles = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            cyc(1'b1, 2'b00);
            if (note_idx_o == 5'd1) found = 1;
            else if (!tone_en_o) gap_cycles++;
        end
        chk("reach_idx1", found, 1);
        chk("gap_len", gap_cycles, TICK_DIV);
        chk("idx1_hp", 32'(half_period_o), 25304);

        // Line clear during entry 1, then music resumes at entry 1
        repeat (3) cyc(1'b1, 2'b00);
        cyc(1'b1, 2'b10);
        cyc(1'b1, 2'b00);
        chk("lc_busy", 32'(sfx_busy_o), 1);
        chk("lc_first_hp", 32'(half_period_o), 28409);
        seen.delete();
        seen.push_back(int'(half_period_o));
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            cyc(1'b1, 2'b00);
            if (!sfx_busy_o) found = 1;
            else if (int'(half_period_o) != seen[$]) seen.push_back(int'(half_period_o));
        end
        chk("lc_end", found, 1);
        chk("lc_tone_count", seen.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("lc_tone", (i < seen.size()) ? seen[i] : -1, lc_exp[i]);
        chk("lc_back_hp", 32'(half_period_o), 25304);
        chk("lc_back_idx", 32'(note_idx_o), 1);

        // Drop preempted by game over; a drop during game over is ignored
        cyc(1'b1, 2'b01);
        cyc(1'b1, 2'b00);
        chk("drop_hp", 32'(half_period_o), 28409);
        cyc(1'b1, 2'b11);
        cyc(1'b1, 2'b00);
        chk("go_preempt_hp", 32'(half_period_o), 18968);
        repeat (2) cyc(1'b1, 2'b00);
        cyc(1'b1, 2'b01);
        cyc(1'b1, 2'b00);
        chk("go_ignore_hp", 32'(half_period_o), 18968);
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            cyc(1'b1, 2'b00);
            if (!sfx_busy_o) found = 1;
        end
        chk("go_end", found, 1);

        // Pause at entry 5, then play again
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            cyc(1'b1, 2'b00);
            if (note_idx_o == 5'd5 && tone_en_o) found = 1;
        end
        chk("reach_idx5", found, 1);
        repeat (3) cyc(1'b0, 2'b00);
        chk("pause_silent", 32'(tone_en_o), 0);
        repeat (2) cyc(1'b1, 2'b00);
`ifdef MELODY_RESUME_EN
        chk("resume_idx", 32'(note_idx_o), 5);
        chk("resume_hp", 32'(half_period_o), 25304);
`else
        chk("restart_idx", 32'(note_idx_o), 0);
        chk("restart_hp", 32'(half_period_o), 18968);
`endif

        // Play through the song end: last entry is a rest, index wraps 31 -> 0
        saw31 = 0; rest_bad = 0; wrapped = 0;
        for (int i = 0; i < 4000 && wrapped == 0; i++) begin
            cyc(1'b1, 2'b00);
            if (note_idx_o == 5'd31) begin
                saw31 = 1;
                if (tone_en_o || half_period_o != '0) rest_bad++;
            end else if (saw31 != 0 && note_idx_o == 5'd0) begin
                wrapped = 1;
            end
        end
        chk("saw_idx31", saw31, 1);
        chk("rest_silent", rest_bad, 0);
        chk("wrap_to_0", wrapped, 1);

        // Random play levels and triggers
        p = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) p = ~p;
            t = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cyc(p, t);
        end

        // Asynchronous reset mid-note
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            cyc(1'b1, 2'b00);
            if (tone_en_o && !sfx_busy_o) found = 1;
        end
        chk("pre_reset_tone", found, 1);
        rst_n = 1'b0;
        #2;
        chk("arst_half_period", 32'(half_period_o), 0);
        chk("arst_tone_en", 32'(tone_en_o), 0);
        chk("arst_note_idx", 32'(note_idx_o), 0);
        chk("arst_sfx_busy", 32'(sfx_busy_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (2) cyc(1'b1, 2'b00);
        chk("post_reset_hp", 32'(half_period_o), 18968);
        repeat (40) cyc(1'b1, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
